age_ordered_rs: RTL and testbench

AGE_ORDERED_RS -- requirements
Module: age_ordered_rs

---
 rtl/age_ordered_rs.sv | 239 +++++++++++++++++++++++
 tb/tb_age_ordered_rs.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: CDB wakeup with allocation bypass, and an
// age matrix so that port k always carries the (k+1)-th oldest ready entry.
module age_ordered_rs #(
    parameter int RS_ENTRIES = 16,
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int PHYS_W     = 6,
    parameter int DATA_W     = 64,
    parameter int OP_W       = 8,
    parameter int ROB_W      = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [DISPATCH_W-1:0]             alloc_en,
    input  logic [OP_W-1:0]                   alloc_op         [DISPATCH_W],
    input  logic [PHYS_W-1:0]                 alloc_dst_tag    [DISPATCH_W],
    input  logic [PHYS_W-1:0]                 alloc_src1_tag   [DISPATCH_W],
    input  logic [PHYS_W-1:0]                 alloc_src2_tag   [DISPATCH_W],
    input  logic [DATA_W-1:0]                 alloc_src1_val   [DISPATCH_W],
    input  logic [DATA_W-1:0]                 alloc_src2_val   [DISPATCH_W],
    input  logic [ROB_W-1:0]                  alloc_rob_tag    [DISPATCH_W],
    input  logic [DISPATCH_W-1:0]             alloc_src1_ready,
    input  logic [DISPATCH_W-1:0]             alloc_src2_ready,
    output logic                              alloc_ready,
    input  logic [CDB_W-1:0]                  cdb_valid,
    input  logic [PHYS_W-1:0]                 cdb_tag          [CDB_W],
    input  logic [DATA_W-1:0]                 cdb_value        [CDB_W],
    input  logic [ISSUE_W-1:0]                issue_ready,
    output logic [ISSUE_W-1:0]                issue_valid,
    output logic [OP_W-1:0]                   issue_op         [ISSUE_W],
    output logic [PHYS_W-1:0]                 issue_dst_tag    [ISSUE_W],
    output logic [DATA_W-1:0]                 issue_src1_val   [ISSUE_W],
    output logic [DATA_W-1:0]                 issue_src2_val   [ISSUE_W],
    output logic [ROB_W-1:0]                  issue_rob_tag    [ISSUE_W],
    output logic [$clog2(RS_ENTRIES+1)-1:0]   occupancy
);
    localparam int IDX_W  = $clog2(RS_ENTRIES);
    localparam int OCC_W  = $clog2(RS_ENTRIES + 1);
    localparam int SLOT_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
    localparam logic [OCC_W-1:0] ALLOC_LIMIT = OCC_W'(RS_ENTRIES - DISPATCH_W);

    logic [RS_ENTRIES-1:0] valid_reg;
    logic [OP_W-1:0]       op_reg      [RS_ENTRIES];
    logic [PHYS_W-1:0]     dst_reg     [RS_ENTRIES];
    logic [ROB_W-1:0]      rob_reg     [RS_ENTRIES];
    logic [PHYS_W-1:0]     s1_tag_reg  [RS_ENTRIES];
    logic [PHYS_W-1:0]     s2_tag_reg  [RS_ENTRIES];
    logic [DATA_W-1:0]     s1_val_reg  [RS_ENTRIES];
    logic [DATA_W-1:0]     s2_val_reg  [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] s1_rdy_reg;
    logic [RS_ENTRIES-1:0] s2_rdy_reg;
    // older_reg[i][j] = 1 means entry i was allocated before entry j
    logic [RS_ENTRIES-1:0] older_reg   [RS_ENTRIES];
    logic [OCC_W-1:0]      occupancy_reg;

    // Returns {hit, value}; scanning downwards lets the lowest matching bus win.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [PHYS_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c] == tag) begin
                res = {1'b1, cdb_value[c]};
            end
        end
        return res;
    endfunction

    logic [RS_ENTRIES-1:0] wake1, wake2;
    logic [DATA_W-1:0]     wake1_val [RS_ENTRIES];
    logic [DATA_W-1:0]     wake2_val [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] elig;
    logic [IDX_W:0]        rank      [RS_ENTRIES];

    assign elig = valid_reg & s1_rdy_reg & s2_rdy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
            assign {wake1[gi], wake1_val[gi]} = cdb_lookup(s1_tag_reg[gi]);
            assign {wake2[gi], wake2_val[gi]} = cdb_lookup(s2_tag_reg[gi]);

            // Number of ready entries older than this one = its issue position.
            always_comb begin
                rank[gi] = '0;
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (elig[j] && older_reg[j][gi]) begin
                        rank[gi] = rank[gi] + (IDX_W + 1)'(1);
                    end
                end
            end
        end
    endgenerate

    logic [DISPATCH_W-1:0] byp1, byp2;
    logic [DATA_W-1:0]     byp1_val  [DISPATCH_W];
    logic [DATA_W-1:0]     byp2_val  [DISPATCH_W];
    logic [DISPATCH_W-1:0] slot_rdy1, slot_rdy2;
    logic [DATA_W-1:0]     slot_val1 [DISPATCH_W];
    logic [DATA_W-1:0]     slot_val2 [DISPATCH_W];

    generate
        for (gi = 0; gi < DISPATCH_W; gi++) begin : g_slot
            assign {byp1[gi], byp1_val[gi]} = cdb_lookup(alloc_src1_tag[gi]);
            assign {byp2[gi], byp2_val[gi]} = cdb_lookup(alloc_src2_tag[gi]);
            assign slot_rdy1[gi] = alloc_src1_ready[gi] | byp1[gi];
            assign slot_rdy2[gi] = alloc_src2_ready[gi] | byp2[gi];
            assign slot_val1[gi] = alloc_src1_ready[gi] ? alloc_src1_val[gi] : byp1_val[gi];
            assign slot_val2[gi] = alloc_src2_ready[gi] ? alloc_src2_val[gi] : byp2_val[gi];
        end
    endgenerate

    logic                  alloc_go;
    logic [RS_ENTRIES-1:0] alloc_mask;
    logic [SLOT_W-1:0]     entry_slot [RS_ENTRIES];

    assign alloc_ready = (occupancy_reg <= ALLOC_LIMIT);
    assign alloc_go    = alloc_ready & ~flush & ~reset;

    // Asserted slots claim the lowest pre-edge free entries, slot 0 first.
    always_comb begin
        logic [RS_ENTRIES-1:0] taken;
        logic                  found;
        taken = '0;
        found = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            entry_slot[i] = '0;
        end
        for (int s = 0; s < DISPATCH_W; s++) begin
            found = 1'b0;
            if (alloc_go && alloc_en[s]) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (!found && !valid_reg[i] && !taken[i]) begin
                        found         = 1'b1;
                        taken[i]      = 1'b1;
                        entry_slot[i] = SLOT_W'(s);
                    end
                end
            end
        end
        alloc_mask = taken;
    end

    logic              sel_hit [ISSUE_W];
    logic [IDX_W-1:0]  sel_idx [ISSUE_W];

    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_port
            always_comb begin
                sel_hit[gi] = 1'b0;
                sel_idx[gi] = '0;
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (elig[i] && rank[i] == (IDX_W + 1)'(gi)) begin
                        sel_hit[gi] = 1'b1;
                        sel_idx[gi] = IDX_W'(i);
                    end
                end
            end
            assign issue_valid[gi]    = sel_hit[gi] & ~flush & ~reset;
            assign issue_op[gi]       = op_reg[sel_idx[gi]];
            assign issue_dst_tag[gi]  = dst_reg[sel_idx[gi]];
            assign issue_src1_val[gi] = s1_val_reg[sel_idx[gi]];
            assign issue_src2_val[gi] = s2_val_reg[sel_idx[gi]];
            assign issue_rob_tag[gi]  = rob_reg[sel_idx[gi]];
        end
    endgenerate

    logic [RS_ENTRIES-1:0] free_mask;
    logic [OCC_W-1:0]      n_alloc, n_issue;

    always_comb begin
        free_mask = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (issue_valid[k] && issue_ready[k]) begin
                free_mask[sel_idx[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        n_alloc = '0;
        n_issue = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            n_alloc = n_alloc + OCC_W'(alloc_mask[i]);
            n_issue = n_issue + OCC_W'(free_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_reg     <= '0;
            occupancy_reg <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                older_reg[i] <= '0;
            end
        end else begin
            occupancy_reg <= occupancy_reg + n_alloc - n_issue;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (alloc_mask[i]) begin
                    valid_reg[i]  <= 1'b1;
                    op_reg[i]     <= alloc_op[entry_slot[i]];
                    dst_reg[i]    <= alloc_dst_tag[entry_slot[i]];
                    rob_reg[i]    <= alloc_rob_tag[entry_slot[i]];
                    s1_tag_reg[i] <= alloc_src1_tag[entry_slot[i]];
                    s2_tag_reg[i] <= alloc_src2_tag[entry_slot[i]];
                    s1_val_reg[i] <= slot_val1[entry_slot[i]];
                    s2_val_reg[i] <= slot_val2[entry_slot[i]];
                    s1_rdy_reg[i] <= slot_rdy1[entry_slot[i]];
                    s2_rdy_reg[i] <= slot_rdy2[entry_slot[i]];
                    // A new entry is older only than later slots of the same group.
                    for (int j = 0; j < RS_ENTRIES; j++) begin
                        older_reg[i][j] <= alloc_mask[j] && (entry_slot[j] > entry_slot[i]);
                    end
                end else begin
                    if (free_mask[i]) begin
                        valid_reg[i] <= 1'b0;
                    end
                    if (!s1_rdy_reg[i] && wake1[i]) begin
                        s1_rdy_reg[i] <= 1'b1;
                        s1_val_reg[i] <= wake1_val[i];
                    end
                    if (!s2_rdy_reg[i] && wake2[i]) begin
                        s2_rdy_reg[i] <= 1'b1;
                        s2_val_reg[i] <= wake2_val[i];
                    end
                    for (int j = 0; j < RS_ENTRIES; j++) begin
                        if (alloc_mask[j]) begin
                            older_reg[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_age_ordered_rs.sv
// Bench for age_ordered_rs: an age-ordered queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_age_ordered_rs;
    localparam int N  = 16;
    localparam int DW = 2;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int PW = 6;
    localparam int XW = 64;
    localparam int OW = 8;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic [DW-1:0] alloc_en, alloc_src1_ready, alloc_src2_ready;
    logic [OW-1:0] alloc_op       [DW];
    logic [PW-1:0] alloc_dst_tag  [DW];
    logic [PW-1:0] alloc_src1_tag [DW];
    logic [PW-1:0] alloc_src2_tag [DW];
    logic [XW-1:0] alloc_src1_val [DW];
    logic [XW-1:0] alloc_src2_val [DW];
    logic [RW-1:0] alloc_rob_tag  [DW];
    logic          alloc_ready;
    logic [CW-1:0] cdb_valid;
    logic [PW-1:0] cdb_tag   [CW];
    logic [XW-1:0] cdb_value [CW];
    logic [IW-1:0] issue_ready, issue_valid;
    logic [OW-1:0] issue_op       [IW];
    logic [PW-1:0] issue_dst_tag  [IW];
    logic [XW-1:0] issue_src1_val [IW];
    logic [XW-1:0] issue_src2_val [IW];
    logic [RW-1:0] issue_rob_tag  [IW];
    logic [$clog2(N+1)-1:0] occupancy;

    age_ordered_rs #(
        .RS_ENTRIES(N), .DISPATCH_W(DW), .ISSUE_W(IW), .CDB_W(CW),
        .PHYS_W(PW), .DATA_W(XW), .OP_W(OW), .ROB_W(RW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_dst_tag(alloc_dst_tag),
        .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_src1_val(alloc_src1_val), .alloc_src2_val(alloc_src2_val),
        .alloc_rob_tag(alloc_rob_tag), .alloc_src1_ready(alloc_src1_ready),
        .alloc_src2_ready(alloc_src2_ready), .alloc_ready(alloc_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_dst_tag(issue_dst_tag), .issue_src1_val(issue_src1_val),
        .issue_src2_val(issue_src2_val), .issue_rob_tag(issue_rob_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: entries kept in allocation order; oldest at index 0.
    typedef struct {
        logic [OW-1:0] op;
        logic [PW-1:0] dst, t1, t2;
        logic [XW-1:0] v1, v2;
        logic [RW-1:0] rob;
        bit            r1, r2;
    } ent_t;

    ent_t          q[$];
    ent_t          nq[$];
    ent_t          e;
    int            el[$];
    bit            rm [N];
    bit            exp_ar, exp_v;
    logic [XW-1:0] fv;

    function automatic bit cdb_find(input logic [PW-1:0] tag, output logic [XW-1:0] v);
        bit found;
        found = 1'b0;
        v     = '0;
        for (int c = 0; c < CW; c++) begin
            if (!found && cdb_valid[c] && cdb_tag[c] == tag) begin
                found = 1'b1;
                v     = cdb_value[c];
            end
        end
        return found;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            el.delete();
            foreach (q[i]) if (q[i].r1 && q[i].r2) el.push_back(i);
            exp_ar = (N - q.size()) >= DW;
            chk("model_occupancy", 128'(occupancy), 128'(q.size()));
            chk("model_alloc_ready", 128'(alloc_ready), 128'(exp_ar));
            for (int i = 0; i < N; i++) rm[i] = 1'b0;
            for (int k = 0; k < IW; k++) begin
                exp_v = (k < el.size()) && !reset && !flush;
                chk($sformatf("model_issue_valid[%0d]", k), 128'(issue_valid[k]), 128'(exp_v));
                if (exp_v) begin
                    e = q[el[k]];
                    chk($sformatf("model_issue_tags[%0d]", k),
                        128'({issue_op[k], issue_dst_tag[k], issue_rob_tag[k]}),
                        128'({e.op, e.dst, e.rob}));
                    chk($sformatf("model_issue_src1[%0d]", k), 128'(issue_src1_val[k]), 128'(e.v1));
                    chk($sformatf("model_issue_src2[%0d]", k), 128'(issue_src2_val[k]), 128'(e.v2));
                    if (issue_ready[k]) begin
                        rm[el[k]] = 1'b1;
                        $display("tb: t=%0t issue port%0d op=%02h dst=p%0d src1=%0d src2=%0d rob=%0d",
                                 $time, k, e.op, e.dst, e.v1, e.v2, e.rob);
                    end
                end
            end
            if (reset || flush) begin
                q.delete();
            end else begin
                nq.delete();
                foreach (q[i]) begin
                    if (!rm[i]) begin
                        e = q[i];
                        if (!e.r1 && cdb_find(e.t1, fv)) begin e.r1 = 1'b1; e.v1 = fv; end
                        if (!e.r2 && cdb_find(e.t2, fv)) begin e.r2 = 1'b1; e.v2 = fv; end
                        nq.push_back(e);
                    end
                end
                if (exp_ar) begin
                    for (int s = 0; s < DW; s++) begin
                        if (alloc_en[s]) begin
                            e.op  = alloc_op[s];       e.dst = alloc_dst_tag[s];
                            e.rob = alloc_rob_tag[s];
                            e.t1  = alloc_src1_tag[s]; e.t2  = alloc_src2_tag[s];
                            e.r1  = alloc_src1_ready[s]; e.v1 = alloc_src1_val[s];
                            e.r2  = alloc_src2_ready[s]; e.v2 = alloc_src2_val[s];
                            if (!e.r1 && cdb_find(e.t1, fv)) begin e.r1 = 1'b1; e.v1 = fv; end
                            if (!e.r2 && cdb_find(e.t2, fv)) begin e.r2 = 1'b1; e.v2 = fv; end
                            nq.push_back(e);
                            $display("tb: t=%0t alloc slot%0d op=%02h dst=p%0d", $time, s, e.op, e.dst);
                        end
                    end
                end
                q = nq;
            end
        end
    end

    task automatic clr();
        flush            = 1'b0;
        alloc_en         = '0;
        alloc_src1_ready = '0;
        alloc_src2_ready = '0;
        cdb_valid        = '0;
        for (int s = 0; s < DW; s++) begin
            alloc_op[s] = '0; alloc_dst_tag[s] = '0; alloc_rob_tag[s] = '0;
            alloc_src1_tag[s] = '0; alloc_src2_tag[s] = '0;
            alloc_src1_val[s] = '0; alloc_src2_val[s] = '0;
        end
        for (int c = 0; c < CW; c++) begin
            cdb_tag[c] = '0; cdb_value[c] = '0;
        end
    endtask

    task automatic put(input int s, input logic [OW-1:0] op, input logic [PW-1:0] dst,
                       input logic [PW-1:0] t1, input logic [XW-1:0] v1, input bit r1,
                       input logic [PW-1:0] t2, input logic [XW-1:0] v2, input bit r2,
                       input logic [RW-1:0] rob);
        alloc_en[s] = 1'b1;
        alloc_op[s] = op; alloc_dst_tag[s] = dst; alloc_rob_tag[s] = rob;
        alloc_src1_tag[s] = t1; alloc_src1_val[s] = v1; alloc_src1_ready[s] = r1;
        alloc_src2_tag[s] = t2; alloc_src2_val[s] = v2; alloc_src2_ready[s] = r2;
    endtask

    // Ready-at-dispatch op numbered n: op=16+n, dst=p<n>, srcs n and n+100.
    task automatic put_n(input int s, input int n);
        put(s, OW'(16 + n), PW'(n), PW'(0), XW'(n), 1'b1, PW'(0), XW'(n + 100), 1'b1, RW'(n));
    endtask

    task automatic cdb(input int c, input logic [PW-1:0] tag, input logic [XW-1:0] val);
        cdb_valid[c] = 1'b1; cdb_tag[c] = tag; cdb_value[c] = val;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        issue_ready = '1;
        clr();
        @(posedge clk);
        chk_on = 1'b1;
        step();
        reset = 1'b0;

        mid();
        chk("reset_occupancy", 128'(occupancy), 128'(0));
        chk("reset_alloc_ready", 128'(alloc_ready), 128'(1));
        chk("reset_issue_valid", 128'(issue_valid), 128'(0));
        step();

        // ADD p10 <- 5,3 and SUB p11 <- p10,7; p10=8 broadcast one cycle later
        put(0, 8'h01, 6'd10, 6'd0, 64'd5, 1'b1, 6'd0, 64'd3, 1'b1, 6'd1);
        put(1, 8'h02, 6'd11, 6'd10, 64'd0, 1'b0, 6'd0, 64'd7, 1'b1, 6'd2);
        step(); clr();
        cdb(0, 6'd10, 64'd8);
        mid();
        chk("add_valid", 128'(issue_valid), 128'(2'b01));
        chk("add_op_dst", 128'({issue_op[0], issue_dst_tag[0]}), 128'({8'h01, 6'd10}));
        chk("add_srcs", {issue_src1_val[0], issue_src2_val[0]}, {64'd5, 64'd3});
        step(); clr();
        mid();
        chk("sub_valid", 128'(issue_valid), 128'(2'b01));
        chk("sub_op_dst", 128'({issue_op[0], issue_dst_tag[0]}), 128'({8'h02, 6'd11}));
        chk("sub_srcs", {issue_src1_val[0], issue_src2_val[0]}, {64'd8, 64'd7});
        step();
        mid();
        chk("sub_drained_occ", 128'(occupancy), 128'(0));
        step();

        // Allocation bypass, two buses match: lowest index supplies 42
        put(0, 8'h03, 6'd21, 6'd20, 64'd0, 1'b0, 6'd0, 64'd1, 1'b1, 6'd3);
        cdb(0, 6'd20, 64'd42);
        cdb(1, 6'd20, 64'd99);
        step(); clr();
        mid();
        chk("bypass_valid", 128'(issue_valid), 128'(2'b01));
        chk("bypass_src1", 128'(issue_src1_val[0]), 128'(42));
        step();

        // Wakeup of a stored entry; no same-cycle CDB-to-issue path
        put(0, 8'h04, 6'd22, 6'd30, 64'd0, 1'b0, 6'd31, 64'd0, 1'b0, 6'd4);
        step(); clr();
        cdb(1, 6'd30, 64'd200);
        cdb(0, 6'd30, 64'd100);
        mid();
        chk("wake_wait1", 128'(issue_valid), 128'(0));
        step(); clr();
        cdb(1, 6'd31, 64'd77);
        mid();
        chk("wake_wait2", 128'(issue_valid), 128'(0));
        step(); clr();
        mid();
        chk("wake_valid", 128'(issue_valid), 128'(2'b01));
        chk("wake_srcs", {issue_src1_val[0], issue_src2_val[0]}, {64'd100, 64'd77});
        step();

        // Fill with port stall; full-group admission only
        issue_ready = 2'b00;
        for (int n = 0; n < 14; n += 2) begin
            put_n(0, n); put_n(1, n + 1);
            step(); clr();
        end
        put_n(0, 14);
        step(); clr();
        put(0, 8'hEE, 6'd60, 6'd0, 64'd0, 1'b1, 6'd0, 64'd0, 1'b1, 6'd60);
        put(1, 8'hEF, 6'd61, 6'd0, 64'd0, 1'b1, 6'd0, 64'd0, 1'b1, 6'd61);
        mid();
        chk("fill_occ15", 128'(occupancy), 128'(15));
        chk("fill_ar15", 128'(alloc_ready), 128'(0));
        step(); clr();
        issue_ready = 2'b01;
        mid();
        chk("drop_occ15", 128'(occupancy), 128'(15));
        chk("fill_oldest_op", 128'(issue_op[0]), 128'(8'h10));
        step();
        issue_ready = 2'b00;
        put_n(0, 15); put_n(1, 16);
        step(); clr();
        put(0, 8'hEE, 6'd60, 6'd0, 64'd0, 1'b1, 6'd0, 64'd0, 1'b1, 6'd60);
        mid();
        chk("fill_occ16", 128'(occupancy), 128'(16));
        chk("fill_ar16", 128'(alloc_ready), 128'(0));
        step(); clr();
        issue_ready = 2'b11;
        mid();
        chk("full_issue_valid", 128'(issue_valid), 128'(2'b11));
        chk("full_issue_order", 128'({issue_op[0], issue_op[1]}), 128'({8'h11, 8'h12}));
        step();
        mid();
        chk("after_issue_occ14", 128'(occupancy), 128'(14));
        chk("after_issue_ar", 128'(alloc_ready), 128'(1));
        step();
        repeat (7) step();
        mid();
        chk("fill_drained", 128'(occupancy), 128'(0));
        step();

        // Flush with five entries, a colliding alloc group and a matching CDB
        issue_ready = 2'b00;
        put_n(0, 40); put_n(1, 41);
        step(); clr();
        put_n(0, 42);
        put(1, 8'h2B, 6'd43, 6'd50, 64'd0, 1'b0, 6'd0, 64'd1, 1'b1, 6'd43);
        step(); clr();
        put_n(0, 44);
        step(); clr();
        issue_ready = 2'b11;
        flush = 1'b1;
        put_n(0, 45); put_n(1, 46);
        cdb(0, 6'd50, 64'd9);
        mid();
        chk("flush_issue_valid", 128'(issue_valid), 128'(0));
        chk("flush_pre_occ", 128'(occupancy), 128'(5));
        step(); clr();
        mid();
        chk("flush_occ", 128'(occupancy), 128'(0));
        chk("flush_no_issue", 128'(issue_valid), 128'(0));
        step();

        // Age order with port 1 stalled: A,B,C = ops 42h,43h,44h
        issue_ready = 2'b00;
        put_n(0, 50); put_n(1, 51);
        step(); clr();
        put_n(0, 52);
        step(); clr();
        issue_ready = 2'b01;
        mid();
        chk("stall_c1_valid", 128'(issue_valid), 128'(2'b11));
        chk("stall_c1_ops", 128'({issue_op[0], issue_op[1]}), 128'({8'h42, 8'h43}));
        step();
        mid();
        chk("stall_c2_ops", 128'({issue_op[0], issue_op[1]}), 128'({8'h43, 8'h44}));
        step();
        mid();
        chk("stall_c3_valid", 128'(issue_valid), 128'(2'b01));
        chk("stall_c3_op", 128'(issue_op[0]), 128'(8'h44));
        step();
        mid();
        chk("stall_drained", 128'(occupancy), 128'(0));
        step();

        // Reset mid-operation (together with flush) discards everything
        issue_ready = 2'b00;
        put_n(0, 60); put_n(1, 61);
        step(); clr();
        reset = 1'b1;
        flush = 1'b1;
        put_n(0, 62);
        mid();
        chk("reset_mid_valid", 128'(issue_valid), 128'(0));
        step();
        reset = 1'b0;
        clr();
        issue_ready = 2'b11;
        put_n(0, 63);
        mid();
        chk("reset_mid_occ", 128'(occupancy), 128'(0));
        chk("reset_mid_ar", 128'(alloc_ready), 128'(1));
        step(); clr();
        mid();
        chk("post_reset_issue", 128'({issue_valid, issue_op[0]}), 128'({2'b01, 8'h4F}));
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
